lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu.sv | 158 +++++++++++++++
 tb/tb_lsu.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Load/store unit: takes one request at a time, checks alignment and width,
// issues a single word-aligned bus access and hands back the extended result.
//
// state | meaning
// IDLE  | ready for a new request
// REQ   | bus request presented, waiting for mem_req_ready
// WAIT  | request taken, waiting for a response or the timeout
// DONE  | result presented downstream, waiting for out_ready
module lsu #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_ren,
  input  logic        in_wen,
  input  logic [2:0]  in_width,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_wen,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wstrb,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_rdata,
  input  logic        mem_resp_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic        out_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          wen_q;
  logic [2:0]    width_q;
  logic [1:0]    off_q;

  logic          accept, is_mem, bad_width, misalign, acc_err, timeout_hit;
  logic [31:0]   st_data, ld_data;
  logic [3:0]    st_strb;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;

  assign in_ready      = (state == IDLE);
  assign mem_req_valid = (state == REQ);
  assign out_valid     = (state == DONE);

  assign accept      = in_valid & in_ready;
  assign is_mem      = in_ren | in_wen;
  assign bad_width   = (in_width == 3'b011) | (in_width[2:1] == 2'b11) | (in_width[2] & in_wen);
  assign misalign    = ((in_width[1:0] == 2'b01) & in_addr[0]) |
                       ((in_width[1:0] == 2'b10) & (|in_addr[1:0]));
  assign acc_err     = bad_width | misalign;
  assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

  always_comb begin
    st_data = in_wdata;
    st_strb = 4'b1111;
    case (in_width[1:0])
      2'b00: begin
        st_data = {4{in_wdata[7:0]}};
        st_strb = 4'b0001 << in_addr[1:0];
      end
      2'b01: begin
        st_data = {2{in_wdata[15:0]}};
        st_strb = in_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = mem_resp_rdata[7:0];
    case (off_q)
      2'd1:    ld_byte = mem_resp_rdata[15:8];
      2'd2:    ld_byte = mem_resp_rdata[23:16];
      2'd3:    ld_byte = mem_resp_rdata[31:24];
      default: ;
    endcase
    ld_half = off_q[1] ? mem_resp_rdata[31:16] : mem_resp_rdata[15:0];
    case (width_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_data = mem_resp_rdata;
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (is_mem && !acc_err) ? REQ : DONE;
      REQ:  if (mem_req_ready) state_nxt = WAIT;
      WAIT: if (mem_resp_valid || timeout_hit) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt           <= '0;
      wen_q         <= 1'b0;
      width_q       <= 3'd0;
      off_q         <= 2'd0;
      mem_req_wen   <= 1'b0;
      mem_req_addr  <= 32'd0;
      mem_req_wdata <= 32'd0;
      mem_req_wstrb <= 4'd0;
      out_rdata     <= 32'd0;
      out_err       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          wen_q         <= in_wen;
          width_q       <= in_width;
          off_q         <= in_addr[1:0];
          mem_req_wen   <= in_wen;
          mem_req_addr  <= {in_addr[31:2], 2'b00};
          mem_req_wdata <= in_wen ? st_data : 32'd0;
          mem_req_wstrb <= in_wen ? st_strb : 4'd0;
          out_rdata     <= 32'd0;
          out_err       <= is_mem & acc_err;
        end
        REQ: if (mem_req_ready) cnt <= '0;
        // a response on the timeout cycle still wins
        WAIT: begin
          if (mem_resp_valid) begin
            out_err   <= mem_resp_err;
            out_rdata <= (mem_resp_err || wen_q) ? 32'd0 : ld_data;
          end else if (timeout_hit) begin
            out_err   <= 1'b1;
            out_rdata <= 32'd0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Randomized bench for lsu: every transaction is predicted by an arithmetic
// model of the access rules and checked cycle by cycle on the falling edge.
module tb_lsu;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0, in_ready, in_ren = 1'b0, in_wen = 1'b0;
  logic [2:0]  in_width = 3'd0;
  logic [31:0] in_addr = 32'd0, in_wdata = 32'd0;
  logic        mem_req_valid, mem_req_ready = 1'b0, mem_req_wen;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_resp_valid = 1'b0, mem_resp_err = 1'b0;
  logic [31:0] mem_resp_rdata = 32'd0;
  logic        out_valid, out_ready = 1'b0, out_err;
  logic [31:0] out_rdata;

  int n_chk = 0;
  int n_bad = 0;

  lsu #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_ren(in_ren), .in_wen(in_wen),
    .in_width(in_width), .in_addr(in_addr), .in_wdata(in_wdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wen(mem_req_wen),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata), .mem_resp_err(mem_resp_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model(input logic ren, input logic wen, input logic [2:0] w,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input logic rerr, input bit timed_out,
                                output bit bus, output logic [31:0] e_wdata, output logic [3:0] e_strb,
                                output logic [31:0] e_rdata, output logic e_err);
    int size, lane;
    bit legal;
    logic [31:0] v;
    size    = (w % 4 == 0) ? 1 : (w % 4 == 1) ? 2 : 4;
    lane    = int'(addr % 4);
    legal   = wen ? (w <= 2) : (w == 0 || w == 1 || w == 2 || w == 4 || w == 5);
    bus     = (ren || wen) && legal && (lane % size == 0);
    e_wdata = 32'd0;
    e_strb  = 4'd0;
    e_rdata = 32'd0;
    e_err   = 1'b0;
    if (!(ren || wen)) return;
    if (!bus) begin
      e_err = 1'b1;
      return;
    end
    if (wen) begin
      e_strb  = 4'(((1 << size) - 1) << lane);
      e_wdata = (size == 1) ? wdata[7:0] * 32'h0101_0101 :
                (size == 2) ? wdata[15:0] * 32'h0001_0001 : wdata;
    end
    if (timed_out) begin
      e_err = 1'b1;
      return;
    end
    e_err = rerr;
    if (rerr || wen) return;
    v = rdata >> (8 * lane);
    if (size < 4) begin
      v = v & ((32'd1 << (8 * size)) - 32'd1);
      if (w < 4 && v[8 * size - 1]) v = v - (32'd1 << (8 * size));
    end
    e_rdata = v;
  endfunction

  task automatic txn(input logic ren, input logic wen, input logic [2:0] w,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input int req_stall, input int resp_at,
                     input logic [31:0] rdata, input logic rerr, input int out_stall);
    bit bus;
    logic [31:0] ew, er;
    logic [3:0] es;
    logic ee;
    model(ren, wen, w, addr, wdata, rdata, rerr, resp_at >= TIMEOUT, bus, ew, es, er, ee);
    @(negedge clk);
    chk("idle_ready", in_ready, 1);
    in_valid = 1'b1; in_ren = ren; in_wen = wen; in_width = w; in_addr = addr; in_wdata = wdata;
    @(negedge clk);
    in_valid = 1'b0; in_ren = 1'($urandom); in_wen = 1'($urandom); in_width = 3'($urandom);
    in_addr = $urandom; in_wdata = $urandom;
    chk("busy_not_ready", in_ready, 0);
    if (bus) begin
      for (int i = 0; i <= req_stall; i++) begin
        chk("req_valid", mem_req_valid, 1);
        chk("req_addr", mem_req_addr, {addr[31:2], 2'b00});
        chk("req_wen", mem_req_wen, wen);
        chk("req_wdata", mem_req_wdata, ew);
        chk("req_wstrb", mem_req_wstrb, es);
        mem_req_ready  = (i == req_stall);
        mem_resp_valid = (i < req_stall) ? 1'($urandom) : 1'b0;
        mem_resp_rdata = $urandom;
        mem_resp_err   = 1'($urandom);
        @(negedge clk);
      end
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      chk("req_valid_drop", mem_req_valid, 0);
      for (int k = 0; k < TIMEOUT; k++) begin
        chk("wait_no_out", out_valid, 0);
        if (k == resp_at) begin
          mem_resp_valid = 1'b1; mem_resp_rdata = rdata; mem_resp_err = rerr;
        end
        @(negedge clk);
        mem_resp_valid = 1'b0; mem_resp_rdata = $urandom; mem_resp_err = 1'($urandom);
        if (k == resp_at) break;
      end
    end else begin
      chk("no_bus_req", mem_req_valid, 0);
    end
    for (int k = 0; k <= out_stall; k++) begin
      chk("out_valid", out_valid, 1);
      chk("out_rdata", out_rdata, er);
      chk("out_err", out_err, ee);
      out_ready = (k == out_stall);
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("out_drop", out_valid, 0);
  endtask

  task automatic reset_mid();
    @(negedge clk);
    in_valid = 1'b1; in_ren = 1'b1; in_wen = 1'b0; in_width = 3'b010; in_addr = 32'h8000_0040;
    @(negedge clk);
    in_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_req_addr", mem_req_addr, 0);
    chk("rst_out_valid", out_valid, 0);
    @(negedge clk);
    rst = 1'b1;
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'hDEAD_BEEF; mem_resp_err = 1'b0;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    chk("late_resp_out_valid", out_valid, 0);
    chk("late_resp_in_ready", in_ready, 1);
    @(negedge clk);
    chk("late_resp_out_valid2", out_valid, 0);
    chk("late_resp_rdata", out_rdata, 0);
  endtask

  initial begin
    logic [2:0] ld_w[5];
    logic ren, wen;
    logic [2:0] w;
    logic [31:0] addr;
    int op, resp_at;
    ld_w = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    repeat (2) @(negedge clk);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_req_valid", mem_req_valid, 0);
    chk("reset_req_wen", mem_req_wen, 0);
    chk("reset_req_addr", mem_req_addr, 0);
    chk("reset_req_wdata", mem_req_wdata, 0);
    chk("reset_req_wstrb", mem_req_wstrb, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_rdata", out_rdata, 0);
    chk("reset_out_err", out_err, 0);
    rst = 1'b1;

    txn(1, 0, 3'b000, 32'h8000_0003, 32'd0, 0, 0, 32'h80AB_CDEF, 0, 0);
    txn(0, 1, 3'b001, 32'h8000_0012, 32'h0000_BEEF, 0, 1, 32'd0, 0, 1);
    txn(1, 0, 3'b010, 32'h8000_0002, 32'd0, 0, 0, 32'd0, 0, 0);
    txn(1, 0, 3'b101, 32'h8000_0002, 32'd0, 5, 2, 32'h1234_8765, 0, 0);
    txn(1, 0, 3'b010, 32'h8000_0100, 32'd0, 0, 99, 32'd0, 0, 3);
    txn(1, 0, 3'b010, 32'h8000_0104, 32'd0, 1, TIMEOUT - 1, 32'hCAFE_F00D, 0, 0);
    txn(1, 0, 3'b001, 32'h8000_0006, 32'd0, 0, 3, 32'h8001_0000, 1, 0);
    txn(0, 0, 3'b111, 32'h0000_0001, 32'd5, 0, 0, 32'd0, 0, 2);
    txn(0, 1, 3'b100, 32'h8000_0000, 32'd5, 0, 0, 32'd0, 0, 0);
    txn(0, 1, 3'b000, 32'h8000_0001, 32'h0000_00A5, 2, 0, 32'd0, 0, 0);
    reset_mid();

    for (int t = 0; t < 150; t++) begin
      op  = $urandom_range(0, 2);
      ren = (op == 1);
      wen = (op == 2);
      if ($urandom_range(0, 3) == 0) w = 3'($urandom);
      else if (wen)                  w = 3'($urandom_range(0, 2));
      else                           w = ld_w[$urandom_range(0, 4)];
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr = (w[1:0] == 2'b10) ? addr & ~32'd3 :
                                            (w[1:0] == 2'b01) ? addr & ~32'd1 : addr;
      resp_at = ($urandom_range(0, 9) == 0) ? TIMEOUT + 3 : $urandom_range(0, 4);
      if ($urandom_range(0, 15) == 0) resp_at = TIMEOUT - 1;
      txn(ren, wen, w, addr, $urandom, $urandom_range(0, 3), resp_at, $urandom,
          1'($urandom_range(0, 5) == 0), $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
